regfile_sb: RTL and testbench

//  Parametrised integer register file for the RISC-V core: NRD combinational read ports,
//  one synchronous write port, optional write-to-read bypass, synchronous reset to a

---
 rtl/regfile_sb.sv | 102 ++++++++++
 tb/tb_regfile_sb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with combinational read ports, one write port, optional
// write-to-read bypass and a busy-bit scoreboard for RAW hazard detection.

module regfile_sb_rport #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                raddr,
  input  logic [NREG-1:0][XLEN-1:0]    regs,
  input  logic [NREG-1:0]              busy,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              rdata,
  output logic                         rbusy
);
  logic hit;

  // A retiring producer forwards its data, so the consumer need not stall on it.
  always_comb begin
    hit   = (BYPASS != 0) && we && (waddr == raddr) && (waddr != '0);
    rdata = hit ? wdata : regs[raddr];
    rbusy = busy[raddr] & ~hit;
  end
endmodule

module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              NRD     = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h000F4240,
  parameter int              BYPASS  = 1,
  localparam int             AW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [AW:0]           busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               busy_cnt_q, busy_cnt_d;
  logic                      set, clr, inc, dec;

  always_comb begin
    set = iss_valid && (iss_rd != '0);
    clr = we && (waddr != '0);

    regs_d = regs_q;
    if (clr) regs_d[waddr] = wdata;
    regs_d[0] = '0;

    // Clear before set: a same-cycle issue to the retiring register is a new producer.
    busy_d = busy_q;
    if (clr) busy_d[waddr] = 1'b0;
    if (set) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    inc = set && !busy_q[iss_rd];
    dec = clr && busy_q[waddr] && !(set && (iss_rd == waddr));
    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (i == 2) ? SP_INIT : '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    regfile_sb_rport #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
    ) u_rport (
      .raddr (raddr[i*AW +: AW]),
      .regs  (regs_q),
      .busy  (busy_q),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[i*XLEN +: XLEN]),
      .rbusy (rbusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing instance share
// stimulus; expectations are queued by the driver and checked by a negedge monitor.

module tb_regfile_sb;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] raddr;
  logic [63:0]   rdata, rdata_nb;
  logic [1:0]    rbusy, rbusy_nb;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW:0]   busy_cnt, busy_cnt_nb;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_cnt(busy_cnt_nb)
  );

  // sel: 0 rdata0, 1 rdata1, 2 rbusy, 3 busy_cnt, 4 nb rdata0, 5 nb busy_cnt, 6 nb rbusy
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return rdata[31:0];
      1: return rdata[63:32];
      2: return {30'b0, rbusy};
      3: return {26'b0, busy_cnt};
      4: return rdata_nb[31:0];
      5: return {26'b0, busy_cnt_nb};
      default: return {30'b0, rbusy_nb};
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exp_q.pop_front();
      a = actual(e.sel);
      n_tests++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0;
    tick();
    rst = 1'b0;

    // Reset state
    raddr = {5'd0, 5'd2};
    expect_v("rst_sp", 0, 32'h000F4240);
    expect_v("rst_r0", 1, 32'h0);
    expect_v("rst_rbusy", 2, 32'h0);
    expect_v("rst_cnt", 3, 32'h0);
    tick();
    raddr = {5'd31, 5'd5};
    expect_v("rst_r5", 0, 32'h0);
    expect_v("rst_r31", 1, 32'h0);
    tick();

    // Write with/without bypass, both ports on one address
    raddr = {5'd5, 5'd5}; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    expect_v("byp_same", 0, 32'hDEADBEEF);
    expect_v("byp_same_p1", 1, 32'hDEADBEEF);
    expect_v("nobyp_same", 4, 32'h0);
    tick();
    we = 1'b0;
    expect_v("byp_next", 0, 32'hDEADBEEF);
    expect_v("nobyp_next", 4, 32'hDEADBEEF);
    tick();

    // Register 0 is hard-wired and never busy
    raddr = {5'd0, 5'd0}; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    expect_v("r0_wr_same", 0, 32'h0);
    tick();
    we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd0;
    expect_v("r0_wr_next", 0, 32'h0);
    tick();
    iss_valid = 1'b0;
    expect_v("r0_iss_cnt", 3, 32'h0);
    expect_v("r0_iss_rbusy", 2, 32'h0);
    tick();

    // Issue then retire reg 7
    raddr = {5'd0, 5'd7}; iss_valid = 1'b1; iss_rd = 5'd7;
    expect_v("r7_iss_same", 2, 32'h0);
    tick();
    iss_valid = 1'b0;
    expect_v("r7_busy", 2, 32'h1);
    expect_v("r7_cnt", 3, 32'h1);
    expect_v("r7_cnt_nb", 5, 32'h1);
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    expect_v("r7_ret_rbusy", 2, 32'h0);
    expect_v("r7_ret_data", 0, 32'h12345678);
    expect_v("r7_ret_rbusy_nb", 6, 32'h1);
    expect_v("r7_ret_cnt", 3, 32'h1);
    tick();
    we = 1'b0;
    expect_v("r7_done_cnt", 3, 32'h0);
    expect_v("r7_done_rbusy", 2, 32'h0);
    tick();

    // Same-cycle issue and write on busy reg 9: set wins
    raddr = {5'd0, 5'd9}; iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    expect_v("r9_cnt", 3, 32'h1);
    tick();
    iss_valid = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h000000AA;
    expect_v("r9_both_rbusy", 2, 32'h0);
    expect_v("r9_both_cnt", 3, 32'h1);
    tick();
    iss_valid = 1'b0; we = 1'b0;
    expect_v("r9_still_busy", 2, 32'h1);
    expect_v("r9_still_cnt", 3, 32'h1);
    expect_v("r9_data", 0, 32'h000000AA);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    expect_v("r9_reiss_cnt", 3, 32'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h000000BB;
    tick();
    waddr = 5'd5; wdata = 32'h55555555;
    expect_v("r9_clr_cnt", 3, 32'h0);
    tick();
    we = 1'b0;
    expect_v("nonbusy_wr_cnt", 3, 32'h0);
    tick();

    // Fill the scoreboard
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_rd = AW'(r);
      expect_v($sformatf("fill_cnt_%0d", r), 3, 32'(r - 1));
      tick();
    end
    iss_valid = 1'b0;
    raddr = {5'd1, 5'd31};
    expect_v("full_cnt", 3, 32'd31);
    expect_v("full_rbusy", 2, 32'h3);
    tick();

    // Reset beats a simultaneous write
    rst = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'h0BADF00D;
    tick();
    rst = 1'b0; we = 1'b0; raddr = {5'd5, 5'd2};
    expect_v("rst2_sp", 0, 32'h000F4240);
    expect_v("rst2_r5", 1, 32'h0);
    expect_v("rst2_cnt", 3, 32'h0);
    expect_v("rst2_cnt_nb", 5, 32'h0);
    expect_v("rst2_rbusy", 2, 32'h0);
    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
